// File: rtl/byte_accumulator.sv
// Frame accumulator: sums a stream of unsigned bytes through the team's 8-bit
// ripple adder and hands off one (sum, count, wrap) result per frame.

module eight_bit_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] sum
);

  logic [7:0] carry;

  always_comb begin
    carry = '0;
    for (int unsigned i = 0; i < 7; i++) begin
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign sum = a ^ b ^ carry;

endmodule

module byte_accumulator #(
  parameter int MAX_OPS = 16,
  parameter int CW      = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  input  logic          in_last,
  input  logic          clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_sum,
  output logic [CW-1:0] out_count,
  output logic          out_ovf
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    out_sum_q, out_sum_d;
  logic [CW-1:0] out_count_q, out_count_d;
  logic          out_ovf_q, out_ovf_d;

  logic [7:0]    add_sum;
  logic [CW-1:0] cnt_inc;
  logic          wrap;

  eight_bit_adder u_adder (
    .a   (acc_q),
    .b   (in_data),
    .sum (add_sum)
  );

  // The adder exposes no carry-out; a mod-256 sum below the addend means it wrapped.
  assign wrap    = (add_sum < in_data);
  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    case (state_q)
      ACCUM: begin
        if (clr) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (in_valid) begin
          acc_d = add_sum;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | wrap;
          if (in_last || (cnt_inc == CW'(MAX_OPS))) begin
            out_sum_d   = add_sum;
            out_count_d = cnt_inc;
            out_ovf_d   = ovf_q | wrap;
            state_d     = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_byte_accumulator.sv
// Directed and randomized bench for byte_accumulator; the reference tracks each
// frame as an unbounded integer total and derives sum/count/wrap from it.

module tb_byte_accumulator;

  localparam int MAX_OPS = 16;
  localparam int CW      = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          in_last;
  logic          clr;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_sum;
  logic [CW-1:0] out_count;
  logic          out_ovf;

  int errors = 0;
  int checks = 0;

  // Reference: frame total as a plain integer; wrap seen iff total reached 256.
  bit m_hold;
  int m_total;
  int m_cnt;
  int e_sum, e_cnt, e_ovf;

  byte_accumulator #(.MAX_OPS(MAX_OPS), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_hold  = 1'b0;
    m_total = 0;
    m_cnt   = 0;
    e_sum   = 0;
    e_cnt   = 0;
    e_ovf   = 0;
  endtask

  task automatic cycle(input bit v, input logic [7:0] d, input bit last,
                       input bit c, input bit ordy);
    in_valid  = v;
    in_data   = d;
    in_last   = last;
    clr       = c;
    out_ready = ordy;
    @(posedge clk);
    if (!m_hold) begin
      if (c) begin
        m_total = 0;
        m_cnt   = 0;
      end else if (v) begin
        m_total += int'(d);
        m_cnt++;
        if (last || m_cnt == MAX_OPS) begin
          e_sum  = m_total % 256;
          e_cnt  = m_cnt;
          e_ovf  = (m_total >= 256) ? 1 : 0;
          m_hold = 1'b1;
        end
      end
    end else if (ordy) begin
      m_hold  = 1'b0;
      m_total = 0;
      m_cnt   = 0;
    end
    #1;
    check("in_ready", 32'(in_ready), 32'(!m_hold));
    check("out_valid", 32'(out_valid), 32'(m_hold));
    if (m_hold) begin
      check("out_sum", 32'(out_sum), 32'(e_sum));
      check("out_count", 32'(out_count), 32'(e_cnt));
      check("out_ovf", 32'(out_ovf), 32'(e_ovf));
    end
  endtask

  // Called at posedge+1; asserts reset mid-cycle and releases it off-edge.
  task automatic async_reset();
    #4;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rel_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    clr       = 1'b0;
    out_ready = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_sum", 32'(out_sum), 32'd0);
    check("reset_out_count", 32'(out_count), 32'd0);
    check("reset_out_ovf", 32'(out_ovf), 32'd0);
    rst_n = 1'b1;
    check("reset_in_ready", 32'(in_ready), 32'd1);

    // Frame sum 0x10+0x20+0x30, then a one-cycle result and a bubble.
    cycle(1, 8'h10, 0, 0, 1);
    cycle(1, 8'h20, 0, 0, 1);
    cycle(1, 8'h30, 1, 0, 1);
    check("fs_sum", 32'(out_sum), 32'h60);
    cycle(0, 8'h00, 0, 0, 1);

    // Wrap detection, then sticky flag cleared on the next frame.
    cycle(1, 8'hF0, 0, 0, 1);
    cycle(1, 8'h20, 1, 0, 0);
    check("wrap_ovf", 32'(out_ovf), 32'd1);
    cycle(0, 8'h00, 0, 0, 1);
    cycle(1, 8'h01, 1, 0, 0);
    check("wrap_cleared", 32'(out_ovf), 32'd0);
    cycle(0, 8'h00, 0, 0, 1);

    // Forced termination at MAX_OPS beats; the 17th beat stalls.
    for (int i = 0; i < MAX_OPS; i++) cycle(1, 8'h01, 0, 0, 0);
    check("force_count", 32'(out_count), 32'(MAX_OPS));
    cycle(1, 8'h01, 0, 0, 0);
    cycle(1, 8'h01, 0, 0, 1);
    cycle(0, 8'h00, 0, 0, 0);

    // Backpressure: five stalled cycles, a one-cycle out_ready pulse, then acc must be 0.
    cycle(1, 8'h44, 1, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 8'h00, 0, 0, 0);
    cycle(0, 8'h00, 0, 0, 1);
    cycle(1, 8'h03, 1, 0, 0);
    check("bp_acc_cleared", 32'(out_sum), 32'h03);
    cycle(0, 8'h00, 0, 0, 1);

    // clr wins over a simultaneous beat.
    cycle(1, 8'h05, 0, 0, 0);
    cycle(1, 8'h09, 0, 1, 0);
    cycle(1, 8'h07, 1, 0, 0);
    check("clr_sum", 32'(out_sum), 32'h07);
    check("clr_count", 32'(out_count), 32'd1);
    // clr in HOLD is ignored.
    cycle(0, 8'h00, 0, 1, 0);
    cycle(0, 8'h00, 0, 0, 1);

    // Asynchronous reset mid-frame.
    cycle(1, 8'h33, 0, 0, 0);
    async_reset();
    cycle(1, 8'h02, 1, 0, 0);
    check("post_rst_sum", 32'(out_sum), 32'h02);
    // Asynchronous reset while a result is pending.
    async_reset();
    cycle(0, 8'h00, 0, 0, 1);

    // Randomized traffic against the reference.
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 5) == 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
